// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - parametrised universal shift register with frame counter
module shift_reg_univ #(
    parameter int               WIDTH     = 5,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] out,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] out_nxt;
    logic             count_op;
    logic             restart;
    logic             last_op;

    assign sout_msb = out[WIDTH-1];
    assign sout_lsb = out[0];
    assign last_op  = (shift_cnt == CNT_LAST);

    // Decode the operation; serial/parallel inputs only reach out_nxt in the modes that use them
    always_comb begin
        out_nxt  = out;
        count_op = 1'b0;
        restart  = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL: begin
                    out_nxt  = {out[WIDTH-2:0], sin_r};
                    count_op = 1'b1;
                end
                MODE_SHR: begin
                    out_nxt  = {sin_l, out[WIDTH-1:1]};
                    count_op = 1'b1;
                end
                MODE_ROL: begin
                    out_nxt  = {out[WIDTH-2:0], out[WIDTH-1]};
                    count_op = 1'b1;
                end
                MODE_ROR: begin
                    out_nxt  = {out[0], out[WIDTH-1:1]};
                    count_op = 1'b1;
                end
                MODE_LOAD: begin
                    out_nxt = pdata;
                    restart = 1'b1;
                end
                MODE_CLEAR: begin
                    out_nxt = '0;
                    restart = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Register contents plus frame counter; frame_done pulses after the WIDTH-th counted op
    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= RESET_VAL;
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            out        <= out_nxt;
            frame_done <= count_op && last_op;
            if (restart) begin
                shift_cnt <= '0;
            end else if (count_op) begin
                shift_cnt <= last_op ? '0 : shift_cnt + CNT_W'(1);
            end
        end
    end

endmodule
